// File: rtl/beat_locking_rr_arbiter_pkg.sv
// Shared parameters and helpers for the beat-locking round-robin arbiter.
package beat_locking_rr_arbiter_pkg;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_BEATS  = 4;
    localparam int DEF_SRC_W  = 2;
    localparam int DEF_DST_W  = 2;
    localparam int DEF_XID_W  = 2;
    localparam int DEF_DATA_W = 64;

    // ceil(log2(v)), never below 1 so counters and indices keep a bit
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/beat_locking_rr_arbiter_pick.sv
// Round-robin priority pick: first valid above last_grant, else lowest valid.
module rr_priority_pick
    import beat_locking_rr_arbiter_pkg::*;
#(
    parameter int N_IN = DEF_N_IN,
    localparam int IDX_W = clog2_min1(N_IN)
) (
    input  logic [N_IN-1:0]  valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] pick
);

    // Descending scans so the lowest matching index is the last write
    always_comb begin
        pick = IDX_W'(N_IN - 1);
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (valid[i]) begin
                pick = IDX_W'(i);
            end
        end
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (valid[i] && (IDX_W'(i) > last_grant)) begin
                pick = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/beat_locking_rr_arbiter.sv
// N-way round-robin arbiter that holds the grant for the full length
// of a data-carrying burst.
module beat_locking_rr_arbiter
    import beat_locking_rr_arbiter_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int BEATS  = DEF_BEATS,
    parameter int SRC_W  = DEF_SRC_W,
    parameter int DST_W  = DEF_DST_W,
    parameter int XID_W  = DEF_XID_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int IDX_W = clog2_min1(N_IN),
    localparam int CNT_W = clog2_min1(BEATS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IN-1:0]          io_in_valid,
    output logic [N_IN-1:0]          io_in_ready,
    input  logic [N_IN-1:0]          io_in_has_data,
    input  logic [N_IN*SRC_W-1:0]    io_in_header_src,
    input  logic [N_IN*DST_W-1:0]    io_in_header_dst,
    input  logic [N_IN*XID_W-1:0]    io_in_xact_id,
    input  logic [N_IN*DATA_W-1:0]   io_in_data,
    input  logic                     io_out_ready,
    output logic                     io_out_valid,
    output logic [SRC_W-1:0]         io_out_header_src,
    output logic [DST_W-1:0]         io_out_header_dst,
    output logic [XID_W-1:0]         io_out_xact_id,
    output logic [DATA_W-1:0]        io_out_data,
    output logic                     io_out_has_data,
    output logic [IDX_W-1:0]         io_chosen,
    output logic                     io_locked
);

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] chosen;
    logic             fire;

    rr_priority_pick #(
        .N_IN (N_IN)
    ) u_pick (
        .valid      (io_in_valid),
        .last_grant (last_grant_q),
        .pick       (pick)
    );

    always_comb begin
        chosen            = locked_q ? lock_idx_q : pick;
        io_out_valid      = io_in_valid[chosen];
        io_out_has_data   = io_in_has_data[chosen];
        io_out_header_src = io_in_header_src[chosen*SRC_W +: SRC_W];
        io_out_header_dst = io_in_header_dst[chosen*DST_W +: DST_W];
        io_out_xact_id    = io_in_xact_id[chosen*XID_W +: XID_W];
        io_out_data       = io_in_data[chosen*DATA_W +: DATA_W];
        io_chosen         = chosen;
        io_locked         = locked_q;
        fire              = io_out_valid & io_out_ready;
        for (int i = 0; i < N_IN; i++) begin
            io_in_ready[i] = io_out_ready && (chosen == IDX_W'(i));
        end
    end

    // Any fired beat counts toward an open burst, header-only or not
    always_comb begin
        last_grant_d = last_grant_q;
        locked_d     = locked_q;
        lock_idx_d   = lock_idx_q;
        beat_cnt_d   = beat_cnt_q;
        if (fire) begin
            last_grant_d = chosen;
            if (locked_q) begin
                if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                    locked_d   = 1'b0;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end else if (io_out_has_data && (BEATS > 1)) begin
                locked_d   = 1'b1;
                lock_idx_d = chosen;
                beat_cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= IDX_W'(N_IN - 1);
            locked_q     <= 1'b0;
            lock_idx_q   <= '0;
            beat_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            lock_idx_q   <= lock_idx_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_beat_locking_rr_arbiter.sv
// Scoreboard bench for beat_locking_rr_arbiter: expected grants are queued
// as stimulus is set up and retired on each output fire.
module tb_beat_locking_rr_arbiter;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int DW = 2;
    localparam int XW = 2;
    localparam int AW = 64;

    logic          clk;
    logic          reset;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [N-1:0]  in_has_data;
    logic [N*SW-1:0] in_src;
    logic [N*DW-1:0] in_dst;
    logic [N*XW-1:0] in_xid;
    logic [N*AW-1:0] in_data;
    logic          out_ready;
    logic          out_valid;
    logic [SW-1:0] out_src;
    logic [DW-1:0] out_dst;
    logic [XW-1:0] out_xid;
    logic [AW-1:0] out_data;
    logic          out_has_data;
    logic [1:0]    chosen;
    logic          locked;

    typedef struct {
        logic [1:0] idx;
        logic       lk;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    beat_locking_rr_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .io_in_valid       (in_valid),
        .io_in_ready       (in_ready),
        .io_in_has_data    (in_has_data),
        .io_in_header_src  (in_src),
        .io_in_header_dst  (in_dst),
        .io_in_xact_id     (in_xid),
        .io_in_data        (in_data),
        .io_out_ready      (out_ready),
        .io_out_valid      (out_valid),
        .io_out_header_src (out_src),
        .io_out_header_dst (out_dst),
        .io_out_xact_id    (out_xid),
        .io_out_data       (out_data),
        .io_out_has_data   (out_has_data),
        .io_chosen         (chosen),
        .io_locked         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] din(input logic [1:0] i);
        return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h1111;
    endfunction

    task automatic set_in(input int i, input logic v, input logic hd);
        in_valid[i]         = v;
        in_has_data[i]      = hd;
        in_src[i*SW +: SW]  = 2'(i);
        in_dst[i*DW +: DW]  = ~2'(i);
        in_xid[i*XW +: XW]  = 2'(i) ^ 2'b01;
        in_data[i*AW +: AW] = din(2'(i));
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) set_in(i, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        exp_t dummy;
        clear_inputs();
        out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_locked: got %b, required 0", locked);
        end
        n_checks++;
        if (chosen !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_idle_chosen: got %0d, required 3", chosen);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_checks++;
        if (in_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 1000", in_ready);
        end
        @(posedge clk);
        #1;
        dummy.idx = 0;
    endtask

    task automatic test_rr_header();
        exp_t e;
        int   guard = 0;
        clear_inputs();
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 1'b0);
        out_ready = 1'b1;
        sb.push_back('{idx: 2'd0, lk: 1'b0});
        sb.push_back('{idx: 2'd1, lk: 1'b0});
        sb.push_back('{idx: 2'd2, lk: 1'b0});
        sb.push_back('{idx: 2'd3, lk: 1'b0});
        sb.push_back('{idx: 2'd0, lk: 1'b0});
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || out_data !== din(e.idx) ||
                    out_src !== e.idx || out_dst !== ~e.idx ||
                    locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL rr_header: chosen=%0d src=%0d dst=%0d data=%h lk=%b, required chosen=%0d lk=%b",
                             chosen, out_src, out_dst, out_data, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_header_timeout: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   guard = 0;
        clear_inputs();
        set_in(1, 1'b1, 1'b0);
        out_ready = 1'b1;
        sb.push_back('{idx: 2'd1, lk: 1'b0});
        while (sb.size() != 0 && guard < 4) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || out_data !== din(e.idx)) begin
                    n_fail++;
                    $display("FAIL wrap_prime: chosen=%0d data=%h, required chosen=%0d",
                             chosen, out_data, e.idx);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        clear_inputs();
        set_in(0, 1'b1, 1'b0);
        set_in(3, 1'b1, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (chosen !== 2'd3 || in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrap_hold: chosen=%0d ready=%b, required chosen=3 ready=0000",
                     chosen, in_ready);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        sb.push_back('{idx: 2'd3, lk: 1'b0});
        guard = 0;
        while (sb.size() != 0 && guard < 4) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || in_ready !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL wrap_hi: chosen=%0d ready=%b, required chosen=%0d ready=1000",
                             chosen, in_ready, e.idx);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        set_in(3, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (chosen !== 2'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_low: chosen=%0d valid=%b, required chosen=0 valid=1",
                     chosen, out_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_timeout: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_burst();
        exp_t e;
        int   guard = 0;
        clear_inputs();
        set_in(0, 1'b1, 1'b0);
        set_in(2, 1'b1, 1'b1);
        out_ready = 1'b1;
        sb.push_back('{idx: 2'd2, lk: 1'b0});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        sb.push_back('{idx: 2'd0, lk: 1'b0});
        while (sb.size() != 0 && guard < 12) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || out_data !== din(e.idx) ||
                    locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL burst: chosen=%0d data=%h lk=%b, required chosen=%0d lk=%b",
                             chosen, out_data, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL burst_timeout: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_bubble();
        exp_t e;
        int   guard = 0;
        clear_inputs();
        set_in(0, 1'b1, 1'b0);
        set_in(2, 1'b1, 1'b1);
        out_ready = 1'b1;
        sb.push_back('{idx: 2'd2, lk: 1'b0});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        while (sb.size() != 0 && guard < 6) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL bubble_head: chosen=%0d lk=%b, required chosen=%0d lk=%b",
                             chosen, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        set_in(2, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || chosen !== 2'd2 ||
                in_ready !== 4'b0100 || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL bubble_gap: valid=%b chosen=%0d ready=%b lk=%b, required 0 2 0100 1",
                         out_valid, chosen, in_ready, locked);
            end
            @(posedge clk);
            #1;
        end
        set_in(2, 1'b1, 1'b1);
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        sb.push_back('{idx: 2'd0, lk: 1'b0});
        guard = 0;
        while (sb.size() != 0 && guard < 8) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL bubble_tail: chosen=%0d lk=%b, required chosen=%0d lk=%b",
                             chosen, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bubble_timeout: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   guard = 0;
        clear_inputs();
        set_in(0, 1'b1, 1'b0);
        set_in(2, 1'b1, 1'b1);
        out_ready = 1'b1;
        sb.push_back('{idx: 2'd2, lk: 1'b0});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        while (sb.size() != 0 && guard < 6) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL stall_head: chosen=%0d lk=%b, required chosen=%0d lk=%b",
                             chosen, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 4'b0000 || chosen !== 2'd2 ||
                locked !== 1'b1 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold: ready=%b chosen=%0d lk=%b valid=%b, required 0000 2 1 1",
                         in_ready, chosen, locked, out_valid);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        sb.push_back('{idx: 2'd0, lk: 1'b0});
        guard = 0;
        while (sb.size() != 0 && guard < 8) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL stall_tail: chosen=%0d lk=%b, required chosen=%0d lk=%b",
                             chosen, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_timeout: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        int   guard = 0;
        clear_inputs();
        set_in(0, 1'b1, 1'b0);
        set_in(2, 1'b1, 1'b1);
        out_ready = 1'b1;
        sb.push_back('{idx: 2'd2, lk: 1'b0});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        while (sb.size() != 0 && guard < 6) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL rstmid_head: chosen=%0d lk=%b, required chosen=%0d lk=%b",
                             chosen, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (locked !== 1'b0 || chosen !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_after: lk=%b chosen=%0d, required lk=0 chosen=0",
                     locked, chosen);
        end
        @(posedge clk);
        #1;
        sb.push_back('{idx: 2'd2, lk: 1'b0});
        sb.push_back('{idx: 2'd2, lk: 1'b1});
        guard = 0;
        while (sb.size() != 0 && guard < 6) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (chosen !== e.idx || locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL rstmid_fresh: chosen=%0d lk=%b, required chosen=%0d lk=%b",
                             chosen, locked, e.idx, e.lk);
                end
            end
            @(posedge clk);
            #1 guard++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_timeout: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = '0;
        in_has_data = '0;
        in_src    = '0;
        in_dst    = '0;
        in_xid    = '0;
        in_data   = '0;
        test_reset();
        test_rr_header();
        test_wrap();
        test_burst();
        test_bubble();
        test_stall();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
